// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: instruction fields,
// ALU control codes, ALU operation classes and FSM state numbering.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   // Operation class handed from the main decode to the ALU decoder.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4
   } state_e;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] alu_op_of(input logic [5:0] op);
      case (op)
         OP_RTYPE: return ALUOP_FUNCT;
         OP_BEQ:   return ALUOP_SUB;
         default:  return ALUOP_ADD;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class and R-type funct field to the 3-bit ALU
// control code; flags funct values the datapath cannot execute.
module alu_decoder
   import cpu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       illegal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: illegal  = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory handshake with timeout, and datapath strobe decode.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       mem_ack,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       mem_req,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       alu_src,
   output logic       reg_dst,
   output logic       reg_write,
   output logic [2:0] alu_ctrl,
   output logic [2:0] state,
   output logic       fault
);

   localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [5:0]       opcode_q, opcode_d;
   logic [5:0]       funct_q, funct_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             gap_q, gap_d;

   logic             in_decode;
   logic [5:0]       cur_op;
   logic [5:0]       cur_fn;
   logic [1:0]       cur_alu_op;
   logic [2:0]       dec_alu_ctrl;
   logic             dec_illegal;
   logic             decode_bad;
   logic             mem_phase;
   logic             acked;
   logic             timeout;

   // DECODE checks the live instruction fields; later states use the latched copy.
   assign in_decode  = (state_q == S_DECODE);
   assign cur_op     = in_decode ? opcode : opcode_q;
   assign cur_fn     = in_decode ? funct  : funct_q;
   assign cur_alu_op = alu_op_of(cur_op);

   alu_decoder u_alu_decoder (
      .alu_op   (cur_alu_op),
      .funct    (cur_fn),
      .alu_ctrl (dec_alu_ctrl),
      .illegal  (dec_illegal)
   );

   assign decode_bad = !op_legal(opcode) || ((opcode == OP_RTYPE) && dec_illegal);

   // gap_q forces one request-free FETCH cycle after a completed or aborted
   // memory access and after reset, so a lingering ack cannot be reused.
   assign mem_phase = ((state_q == S_FETCH) || (state_q == S_MEM)) && !gap_q;
   assign acked     = mem_phase && mem_ack;
   assign timeout   = mem_phase && !mem_ack && (wait_q == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
         funct_q  <= '0;
         wait_q   <= '0;
         gap_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         funct_q  <= funct_d;
         wait_q   <= wait_d;
         gap_q    <= gap_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      funct_d  = funct_q;
      wait_d   = wait_q;
      gap_d    = 1'b0;

      if (mem_phase) begin
         if (mem_ack || timeout) begin
            wait_d = '0;
            gap_d  = 1'b1;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end

      case (state_q)
         S_FETCH: begin
            if (acked) state_d = S_DECODE;
         end
         S_DECODE: begin
            opcode_d = opcode;
            funct_d  = funct;
            state_d  = decode_bad ? S_FETCH : S_EXECUTE;
         end
         S_EXECUTE: begin
            case (opcode_q)
               OP_LW, OP_SW: state_d = S_MEM;
               OP_BEQ:       state_d = S_FETCH;
               default:      state_d = S_WRITEBACK;
            endcase
         end
         S_MEM: begin
            if (acked)        state_d = (opcode_q == OP_SW) ? S_FETCH : S_WRITEBACK;
            else if (timeout) state_d = S_FETCH;
         end
         S_WRITEBACK: state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src       = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_ctrl      = ALU_ADD;
      fault         = 1'b0;

      if (rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req  = !gap_q;
               ir_write = acked;
               pc_write = acked;
               fault    = timeout;
            end
            S_DECODE: fault = decode_bad;
            S_EXECUTE: begin
               alu_ctrl      = dec_alu_ctrl;
               alu_src       = (opcode_q == OP_LW) || (opcode_q == OP_SW) || (opcode_q == OP_ADDI);
               pc_write_cond = (opcode_q == OP_BEQ) && alu_zero;
            end
            S_MEM: begin
               mem_req   = !gap_q;
               mem_write = !gap_q && (opcode_q == OP_SW);
               fault     = timeout;
            end
            S_WRITEBACK: begin
               reg_write  = 1'b1;
               reg_dst    = (opcode_q == OP_RTYPE);
               mem_to_reg = (opcode_q == OP_LW);
            end
            default: ;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, giving the max cycles waiting for mem_ack before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port funct, input, 6, instruction bits [5:0].
REQ-006 SHALL have port alu_zero, input, 1, ALU zero flag during EXECUTE.
REQ-007 SHALL have port mem_ack, input, 1, memory completion, valid only while mem_req=1.
REQ-008 SHALL have outputs ir_write, pc_write, pc_write_cond, mem_req, mem_write, mem_to_reg, alu_src, reg_dst, reg_write, each 1 bit, the datapath strobes/selects.
REQ-009 SHALL have output alu_ctrl, 3 bits: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 SHALL have output state, 3 bits, current FSM state for debug.
REQ-011 SHALL have output fault, 1 bit, a one-cycle pulse on illegal opcode/funct or memory timeout.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4; encodings 5-7 SHALL go to FETCH.
REQ-013 FETCH SHALL hold mem_req=1, mem_write=0 until mem_ack; in the ack cycle it SHALL pulse ir_write=1 and pc_write=1, then go to DECODE.
REQ-014 DECODE SHALL last exactly one cycle, asserting no strobes, and go to EXECUTE; illegal opcode or R-type funct SHALL pulse fault and go to FETCH.
REQ-015 Supported opcodes: 000000 R-type (funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt), 100011 lw, 101011 sw, 000100 beq, 001000 addi.
REQ-016 EXECUTE SHALL drive alu_ctrl: R-type from funct; lw/sw/addi 010 with alu_src=1; beq 110 with alu_src=0.
REQ-017 beq SHALL assert pc_write_cond=alu_zero for one EXECUTE cycle and then return to FETCH (3 cycles + fetch wait).
REQ-018 R-type and addi SHALL go EXECUTE->WRITEBACK; lw and sw SHALL go EXECUTE->MEM.
REQ-019 MEM SHALL hold mem_req=1 (mem_write=1 for sw) until mem_ack; then sw goes to FETCH and lw goes to WRITEBACK.
REQ-020 WRITEBACK SHALL pulse reg_write=1 for one cycle with reg_dst=1, mem_to_reg=0 for R-type; reg_dst=0, mem_to_reg=0 for addi; reg_dst=0, mem_to_reg=1 for lw; then go to FETCH.
REQ-021 mem_ack while mem_req=0 SHALL be ignored; mem_req SHALL drop in the cycle after the ack cycle.
REQ-022 A wait counter SHALL count cycles with mem_req=1 and no ack; reaching MEM_TIMEOUT SHALL pulse fault, drop mem_req and go to FETCH with no reg_write or pc_write.
REQ-023 Datapath outputs SHALL be Moore decodes of state plus the latched opcode/funct, except ir_write/pc_write (gated by mem_ack) and pc_write_cond (gated by alu_zero).
REQ-024 opcode/funct SHALL be latched in DECODE and held through the end of the instruction.

Reset
REQ-025 With rst=0 at a clock edge, state SHALL become FETCH, the wait counter 0 and latched opcode/funct 0.
REQ-026 While in reset, all strobes, fault and mem_req SHALL be 0, alu_ctrl 010, and selects 0.
REQ-027 Reset mid-instruction SHALL abandon it; no write strobe SHALL assert in the cycle after the reset edge.

Structure
REQ-028 A shared package cpu_pkg SHALL hold the opcode and funct constants, alu_ctrl codes and the state encoding.
REQ-029 The funct-to-alu_ctrl mapping SHALL be a combinational sub-module alu_decoder (inputs alu_op[1:0], funct; outputs alu_ctrl, illegal).

Verification
REQ-030 add, ack in 1 cycle: states 0,1,2,4,0; reg_write=1 only in WRITEBACK with reg_dst=1, alu_ctrl=010.
REQ-031 lw, memory acks 3 cycles after request: MEM holds mem_req 3 cycles; reg_write=1 with mem_to_reg=1 the cycle after ack.
REQ-032 beq with alu_zero=1, then alu_zero=0: pc_write_cond 1 then 0 in EXECUTE; both return to FETCH with no reg_write.
REQ-033 opcode 111111: fault=1 for one cycle at DECODE, next state 0, no writes; sw with mem_ack never asserted: fault after 15 wait cycles, mem_req=0 next.
REQ-034 rst=0 during lw MEM: next cycle state=0, mem_req=0; a held-high mem_ack with mem_req=0 is ignored.
